// File: rtl/load_store_unit.sv
// Load/store unit: sub-doubleword stores are done as read-modify-write of the 8 bytes at the
// target address on a big-endian, 64-bit memory bus.
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rw,
  output logic [63:0] addr,
  inout  wire  [63:0] mem_data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeDbl  = 2'b11;

  // Every access touches 8 bytes, so the last legal address is MEM_SIZE-8 for all sizes.
  localparam logic [63:0] LastAddr = 64'(MEM_SIZE) - 64'd8;

  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        err_q;
  logic [63:0] rbuf_q;

  logic        accept;
  logic        range_err;
  logic [63:0] wr_data;
  logic [63:0] load_val;
  logic        sx;

  assign accept    = (state_q == StIdle) && req_valid;
  assign range_err = req_addr > LastAddr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (range_err) begin
            state_d = StResp;
          end else if (req_we && (req_size == SizeDbl)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:   state_d = we_q ? StWr : StResp;
      StWr:   state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      err_q   <= 1'b0;
      rbuf_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= range_err;
      end
      if (state_q == StRd) begin
        rbuf_q <= mem_data;
      end
    end
  end

  // New data replaces the most-significant (lowest-addressed) bytes of the fetched doubleword.
  always_comb begin
    wr_data = wdata_q;
    unique case (size_q)
      SizeByte: wr_data = {wdata_q[7:0],  rbuf_q[55:0]};
      SizeHalf: wr_data = {wdata_q[15:0], rbuf_q[47:0]};
      SizeWord: wr_data = {wdata_q[31:0], rbuf_q[31:0]};
      SizeDbl:  wr_data = wdata_q;
      default:  wr_data = wdata_q;
    endcase
  end

  assign sx = ~uns_q;

  always_comb begin
    load_val = rbuf_q;
    unique case (size_q)
      SizeByte: load_val = {{56{sx & rbuf_q[63]}}, rbuf_q[63:56]};
      SizeHalf: load_val = {{48{sx & rbuf_q[63]}}, rbuf_q[63:48]};
      SizeWord: load_val = {{32{sx & rbuf_q[63]}}, rbuf_q[63:32]};
      SizeDbl:  load_val = rbuf_q;
      default:  load_val = rbuf_q;
    endcase
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = (state_q == StResp) && err_q;
  assign resp_rdata = ((state_q == StResp) && !we_q && !err_q) ? load_val : 64'd0;

  assign mem_rw   = (state_q == StWr);
  assign addr     = addr_q;
  assign mem_data = mem_rw ? wr_data : 64'bz;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: big-endian byte memory model on the shared bus, a directed
// vector table, and hand-written back-to-back and reset-abort sequences.
module tb_load_store_unit;

  localparam int MemSize = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_rw;
  logic [63:0] addr;
  wire  [63:0] mem_data;

  logic        mem_clr;
  logic [7:0]  mem [MemSize];
  logic [63:0] mem_rd;
  int          acc_cnt;

  load_store_unit #(.MEM_SIZE(MemSize)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_rw       (mem_rw),
    .addr         (addr),
    .mem_data     (mem_data)
  );

  always #5 clk = ~clk;

  // Combinational big-endian read; out-of-range bytes read as zero.
  always_comb begin
    logic [63:0] ai;
    mem_rd = '0;
    for (int i = 0; i < 8; i++) begin
      ai = addr + 64'(i);
      if (ai < 64'(MemSize)) mem_rd[63-8*i -: 8] = mem[ai[12:0]];
    end
  end

  assign mem_data = (mem_rw === 1'b1) ? 64'bz : mem_rd;

  always @(negedge clk) begin
    logic [63:0] wa;
    if (mem_clr) begin
      for (int i = 0; i < MemSize; i++) mem[i] <= 8'h00;
    end else if (mem_rw === 1'b1) begin
      for (int i = 0; i < 8; i++) begin
        wa = addr + 64'(i);
        if (wa < 64'(MemSize)) mem[wa[12:0]] <= mem_data[63-8*i -: 8];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) acc_cnt <= 0;
    else if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] a;
    logic [63:0] wd;
    logic        err;
    logic [63:0] rd;
    int          lat;
    int          wrs;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nfail = 0;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [63:0] a, input logic [63:0] wd, input logic err,
                              input logic [63:0] rd, input int lat, input int wrs);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.a = a; v.wd = wd;
    v.err = err; v.rd = rd; v.lat = lat; v.wrs = wrs;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Entered just after a negedge; returns just after the negedge that shows resp_valid.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int lat;
    int wrs;
    logic err;
    logic [63:0] rd;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.a; req_wdata = v.wd;
    @(posedge clk);
    #1;
    // Scramble the request fields to show they were latched at the accept edge.
    req_valid = 1'b0; req_we = ~v.we; req_size = ~v.size; req_unsigned = ~v.uns;
    req_addr = '1; req_wdata = ~v.wd;
    lat = 0; wrs = 0; err = 1'bx; rd = 'x;
    forever begin
      @(negedge clk);
      lat++;
      if (mem_rw === 1'b1) wrs++;
      if (resp_valid === 1'b1) begin
        err = resp_err;
        rd = resp_rdata;
        break;
      end
      if (lat >= 8) begin
        lat = 99;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " resp_err"}, {63'd0, err}, {63'd0, v.err});
    check({tag, " resp_rdata"}, rd, v.rd);
    check({tag, " mem_rw cycles"}, 64'(wrs), 64'(v.wrs));
  endtask

  initial begin
    int lat;
    int seen;
    int acc0;
    logic ready_seen;

    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    //            we    size   uns   addr                    wdata                  err   rdata                  lat wrs
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 64'h10,  64'h0123456789ABCDEF, 1'b0, 64'h0,                 2, 1));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 64'h10,  64'h0,                1'b0, 64'h0123456789ABCDEF, 2, 0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 64'h11,  64'hFFFFFFFFFFFFFFAA, 1'b0, 64'h0,                 3, 1));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 64'h10,  64'h0,                1'b0, 64'h01AA456789ABCDEF, 2, 0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 64'h14,  64'h0,                1'b0, 64'hFFFFFFFF89ABCDEF, 2, 0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 64'h17,  64'h0,                1'b0, 64'h00000000000000EF, 2, 0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 64'h10,  64'h0,                1'b0, 64'h00000000000001AA, 2, 0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 64'h14,  64'h0,                1'b0, 64'hFFFFFFFFFFFFFF89, 2, 0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 64'h14,  64'h0,                1'b0, 64'h00000000000089AB, 2, 0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b1, 64'h14,  64'h0,                1'b0, 64'h0000000089ABCDEF, 2, 0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 64'h20,  64'hDEADBEEF12345678, 1'b0, 64'h0,                 3, 1));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 64'h20,  64'h0,                1'b0, 64'h1234567800000000, 2, 0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 64'h16,  64'h0000000000005A5A, 1'b0, 64'h0,                 3, 1));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 64'h10,  64'h0,                1'b0, 64'h01AA456789AB5A5A, 2, 0));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 64'h1FF9, 64'h0,               1'b1, 64'h0,                 1, 0));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 64'h1FF9, 64'h1111111111111111, 1'b1, 64'h0,                1, 0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 64'h1FFF, 64'h22,              1'b1, 64'h0,                 1, 0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 64'h8000000000000010, 64'h0,   1'b1, 64'h0,                 1, 0));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 64'h1FF8, 64'hCAFEF00D12345678, 1'b0, 64'h0,                2, 1));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 64'h1FF8, 64'h0,               1'b0, 64'hCAFEF00D12345678, 2, 0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 64'h1FF8, 64'h0,               1'b0, 64'h00000000000000CA, 2, 0));

    repeat (3) @(negedge clk);
    check("reset req_ready", {63'd0, req_ready}, 64'd1);
    check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset resp_err", {63'd0, resp_err}, 64'd0);
    check("reset resp_rdata", resp_rdata, 64'd0);
    check("reset mem_rw", {63'd0, mem_rw}, 64'd0);
    check("reset addr", addr, 64'd0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back stores with req_valid held high throughout.
    @(negedge clk);
    acc0 = acc_cnt;
    ready_seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 64'h40; req_wdata = 64'h1122334455667788;
    @(posedge clk);
    #1;
    req_addr = 64'h48; req_size = 2'b01; req_wdata = 64'h000000000000BEEF;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready !== 1'b0) ready_seen = 1'b1;
    end while (resp_valid !== 1'b1 && lat < 8);
    check("b2b first latency", 64'(lat), 64'd2);
    @(negedge clk);
    check("b2b ready after resp", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready !== 1'b0) ready_seen = 1'b1;
    end while (resp_valid !== 1'b1 && lat < 8);
    check("b2b second latency", 64'(lat), 64'd3);
    check("b2b ready low while busy", {63'd0, ready_seen}, 64'd0);
    check("b2b accept count", 64'(acc_cnt - acc0), 64'd2);
    @(negedge clk);
    run_vec(mk(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 1'b0, 64'h1122334455667788, 2, 0), "b2b rd40");
    run_vec(mk(1'b0, 2'b11, 1'b0, 64'h48, 64'h0, 1'b0, 64'hBEEF000000000000, 2, 0), "b2b rd48");
    run_vec(mk(1'b0, 2'b11, 1'b0, 64'h44, 64'h0, 1'b0, 64'h55667788BEEF0000, 2, 0), "b2b rd44");

    // Reset during the RD cycle of a load aborts it without a response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 64'h10; req_wdata = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort busy in RD", {63'd0, req_ready}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort ready after reset", {63'd0, req_ready}, 64'd1);
    check("abort addr after reset", addr, 64'd0);
    seen = (resp_valid === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    check("abort no resp_valid", 64'(seen), 64'd0);
    run_vec(mk(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 1'b0, 64'h01AA456789AB5A5A, 2, 0), "post-abort");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 8192: data-memory size in bytes.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  pipeline request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr  input  64  byte address.
REQ-010 SHALL have port req_wdata  input  64  store data, right-aligned (LSBs valid).
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  64  extended load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  out-of-range access, valid with resp_valid.
REQ-014 SHALL have port mem_rw  output  1  memory write enable: 1 = write, 0 = read.
REQ-015 SHALL have port addr  output  64  memory byte address.
REQ-016 SHALL have port mem_data  inout  64  memory data bus; driven only while mem_rw = 1, else high-Z.

Function
REQ-017 SHALL treat memory as big-endian: a doubleword at A has byte A in bits 63:56 and byte A+7 in bits 7:0; memory reads are combinational, memory writes commit on the negedge of a cycle with mem_rw = 1.
REQ-018 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL, in IDLE with req_valid = 1, latch we/size/unsigned/addr/wdata and go to RESP with err set if req_addr > MEM_SIZE-8, else to WR for double stores, else to RD.
REQ-020 SHALL, in RD, hold mem_rw = 0, drive addr = latched address, and capture mem_data into a read buffer at the posedge; the next state is RESP for loads and WR for stores.
REQ-021 SHALL, in WR, hold mem_rw = 1 for exactly one cycle, drive addr = latched address, and drive the merged data: byte {wdata[7:0], rbuf[55:0]}, half {wdata[15:0], rbuf[47:0]}, word {wdata[31:0], rbuf[31:0]}, double wdata; the next state is RESP.
REQ-022 SHALL, in RESP, assert resp_valid for one cycle, then return to IDLE; requests arriving during RESP wait until IDLE.
REQ-023 SHALL form load results from rbuf top bytes: byte rbuf[63:56], half rbuf[63:48], word rbuf[63:32], double rbuf; then zero- or sign-extend to 64 bits per the latched unsigned flag.
REQ-024 SHALL give latencies from the accept edge to the resp_valid cycle of: load 2 cycles, double store 2, sub-double store 3, error 1.
REQ-025 SHALL never assert mem_rw for an errored request; resp_rdata = 0 and resp_err = 1 in its RESP cycle.
REQ-026 SHALL keep mem_rw = 0 and addr stable at the last latched value outside RD/WR; mem_data SHALL be high-Z whenever mem_rw = 0.
REQ-027 SHALL ignore req_* inputs whenever req_ready = 0.

Reset
REQ-028 SHALL, with rst = 1 at a posedge, enter IDLE and force req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_rw = 0, addr = 0, and read buffer = 0.
REQ-029 SHALL abort any in-flight request on reset with no resp_valid; a WR cycle already in progress when rst rises still commits at that cycle's negedge.

Verification
REQ-030 SHALL cover: after reset, store double 0x0123456789ABCDEF at 0x10, then load double at 0x10 -> resp_rdata 0x0123456789ABCDEF, 2 cycles after the accept edge.
REQ-031 SHALL cover: then store byte 0xAA at 0x11 (with mem_rw high exactly one cycle), then load double at 0x10 -> 0x01AA456789ABCDEF.
REQ-032 SHALL cover: signed word load at 0x14 -> 0xFFFFFFFF89ABCDEF; unsigned byte load at 0x17 -> 0x00000000000000EF; signed half load at 0x10 -> 0x00000000000001AA.
REQ-033 SHALL cover: load at 0x1FF9 -> resp_valid with resp_err = 1 and resp_rdata = 0 one cycle after the accept edge, with mem_rw never 1.
REQ-034 SHALL cover: rst asserted during the RD cycle of a load -> no resp_valid, and req_ready = 1 on the next cycle.
REQ-035 SHALL cover: req_valid held high across back-to-back stores -> req_ready low from the accept edge until RESP completes, and each request is accepted exactly once.
